// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for a 16x16 LED dot matrix: fetches one column word per row,
// shows it with blanking between rows, and steps through stored patterns on frame boundaries.
module matrix_scan_ctrl #(
  parameter int ROW_TICKS      = 2500,
  parameter int BLANK_TICKS    = 8,
  parameter int FRAMES_PER_PAT = 100,
  parameter int NUM_PAT        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        auto_en,
  input  logic        step,
  input  logic [15:0] pat_col_in,
  output logic [3:0]  row_bin,
  output logic [3:0]  pat_sel,
  output logic [15:0] row_out,
  output logic [15:0] col_out,
  output logic        frame_done
);

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int PW        = $clog2(MAX_TICKS + 1);
  localparam int FW        = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_TICKS - 1);
  localparam logic [PW-1:0] ROW_LAST   = PW'(ROW_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PAT - 1);
  localparam logic [3:0]    PAT_LAST   = 4'(NUM_PAT - 1);

  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [FW-1:0] frame_cnt;
  logic          step_pending;

  logic          blank_end;
  logic          show_end;
  logic          boundary;
  logic          advance;
  logic [3:0]    pat_next;
  logic [FW-1:0] frame_next;

  // row_bin doubles as the row index, so the ROMs see it stable from BLANK entry onward.
  always_comb begin
    blank_end  = 1'b0;
    show_end   = 1'b0;
    boundary   = 1'b0;
    advance    = 1'b0;
    pat_next   = 4'd0;
    frame_next = '0;
    blank_end  = (state == ST_BLANK) && (phase == BLANK_LAST);
    show_end   = (state == ST_SHOW) && (phase == ROW_LAST);
    boundary   = show_end && (row_bin == 4'd15);
    advance    = boundary &&
                 ((auto_en && (frame_cnt == FRAME_LAST)) || step_pending || step);
    pat_next   = (pat_sel >= PAT_LAST) ? 4'd0 : 4'(pat_sel + 4'd1);
    frame_next = (frame_cnt == FRAME_LAST) ? '0 : FW'(frame_cnt + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BLANK;
      phase        <= '0;
      frame_cnt    <= '0;
      step_pending <= 1'b0;
      row_bin      <= 4'd0;
      pat_sel      <= 4'd0;
      row_out      <= 16'd0;
      col_out      <= 16'd0;
      frame_done   <= 1'b0;
    end else if (!en) begin
      // Go dark and restart the current row's blanking, but remember where we were.
      state        <= ST_BLANK;
      phase        <= '0;
      row_out      <= 16'd0;
      col_out      <= 16'd0;
      frame_done   <= 1'b0;
      step_pending <= step_pending | step;
    end else begin
      frame_done <= boundary;
      case (state)
        ST_BLANK: begin
          row_out <= 16'd0;
          col_out <= 16'd0;
          if (blank_end) begin
            state <= ST_FETCH;
            phase <= '0;
          end else begin
            phase <= PW'(phase + 1'b1);
          end
        end
        ST_FETCH: begin
          // Column word and row enable switch together, both coming out of a dark cycle.
          state   <= ST_SHOW;
          phase   <= '0;
          row_out <= 16'd1 << row_bin;
          col_out <= pat_col_in;
        end
        ST_SHOW: begin
          if (show_end) begin
            state   <= ST_BLANK;
            phase   <= '0;
            row_out <= 16'd0;
            col_out <= 16'd0;
            row_bin <= 4'(row_bin + 4'd1);
          end else begin
            phase <= PW'(phase + 1'b1);
          end
        end
        default: begin
          state   <= ST_BLANK;
          phase   <= '0;
          row_out <= 16'd0;
          col_out <= 16'd0;
        end
      endcase

      if (boundary) begin
        frame_cnt    <= frame_next;
        step_pending <= 1'b0;
        if (advance) begin
          pat_sel <= pat_next;
        end
      end else begin
        step_pending <= step_pending | step;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: a per-cycle position model predicts every
// registered output, plus directed checks on pattern sequencing, en dropout and async reset.
module tb_matrix_scan_ctrl;

  localparam int ROW_TICKS      = 4;
  localparam int BLANK_TICKS    = 2;
  localparam int FRAMES_PER_PAT = 2;
  localparam int NUM_PAT        = 3;
  localparam int PERIOD         = BLANK_TICKS + 1 + ROW_TICKS;
  localparam int FRAME          = 16 * PERIOD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        auto_en = 1'b0;
  logic        step = 1'b0;
  logic [15:0] pat_col_in;
  logic [3:0]  row_bin;
  logic [3:0]  pat_sel;
  logic [15:0] row_out;
  logic [15:0] col_out;
  logic        frame_done;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .ROW_TICKS(ROW_TICKS),
    .BLANK_TICKS(BLANK_TICKS),
    .FRAMES_PER_PAT(FRAMES_PER_PAT),
    .NUM_PAT(NUM_PAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .auto_en(auto_en),
    .step(step),
    .pat_col_in(pat_col_in),
    .row_bin(row_bin),
    .pat_sel(pat_sel),
    .row_out(row_out),
    .col_out(col_out),
    .frame_done(frame_done)
  );

  // Pattern ROM stand-in: row*0x1111, with the pattern index folded into the top nibble.
  function automatic logic [15:0] rom_word(input logic [3:0] r, input logic [3:0] p);
    logic [15:0] base;
    base = 16'({12'h000, r} * 16'h1111);
    return base ^ {p, 12'h000};
  endfunction

  assign pat_col_in = rom_word(row_bin, pat_sel);

  int          n_vec = 0;
  int          n_err = 0;
  int          fd_seen = 0;
  logic [40:0] sb_q[$];
  logic [40:0] mon_exp;
  logic [3:0]  prev_row = 4'd0;
  logic [3:0]  prev_pat = 4'd0;

  int          m_pos;
  int          m_frames;
  logic [3:0]  m_row;
  logic [3:0]  m_pat;
  logic        m_pend;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pos    = 0;
    m_frames = 0;
    m_row    = 4'd0;
    m_pat    = 4'd0;
    m_pend   = 1'b0;
    sb_q.delete();
  endtask

  // Called at a negedge: drive inputs, predict the post-edge outputs, advance one cycle.
  task automatic applyStimulus(input logic e, input logic a, input logic s);
    logic [15:0] x_row;
    logic [15:0] x_col;
    logic        x_fd;
    logic        boundary;
    logic        adv;
    en      = e;
    auto_en = a;
    step    = s;
    x_row   = 16'd0;
    x_col   = 16'd0;
    x_fd    = 1'b0;
    if (!e) begin
      m_pos  = 0;
      m_pend = m_pend | s;
    end else begin
      boundary = (m_pos == PERIOD - 1) && (m_row == 4'd15);
      x_fd     = boundary;
      if (m_pos == PERIOD - 1) begin
        m_pos = 0;
        m_row = m_row + 4'd1;
      end else begin
        m_pos++;
        if (m_pos > BLANK_TICKS) begin
          x_row = 16'd1 << m_row;
          x_col = rom_word(m_row, m_pat);
        end
      end
      if (boundary) begin
        adv      = (a && (m_frames == FRAMES_PER_PAT - 1)) || m_pend || s;
        m_frames = (m_frames == FRAMES_PER_PAT - 1) ? 0 : m_frames + 1;
        if (adv) m_pat = (m_pat == 4'(NUM_PAT - 1)) ? 4'd0 : m_pat + 4'd1;
        m_pend = 1'b0;
      end else begin
        m_pend = m_pend | s;
      end
    end
    sb_q.push_back({m_row, m_pat, x_row, x_col, x_fd});
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      checkOutput("cycle", {23'd0, row_bin, pat_sel, row_out, col_out, frame_done}, {23'd0, mon_exp});
      if (pat_sel !== prev_pat)
        checkOutput("pat_chg_row", {56'd0, prev_row, row_bin}, {56'd0, 8'hF0});
    end
    fd_seen  = fd_seen + int'(frame_done);
    prev_row = row_bin;
    prev_pat = pat_sel;
  end

  logic [3:0] auto_tbl[6] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0};

  initial begin
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outs", {23'd0, row_bin, pat_sel, row_out, col_out, frame_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    fd_seen = 0;
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fd_per_frame", 64'(fd_seen), 64'd1);

    for (int k = 0; k < 6; k++) begin
      repeat (FRAME) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("auto_pat", {60'd0, pat_sel}, {60'd0, auto_tbl[k]});
    end

    for (int c = 0; c < FRAME; c++)
      applyStimulus(1'b1, 1'b0, (c == 20 || c == 40 || c == 60) ? 1'b1 : 1'b0);
    checkOutput("step_pat", {60'd0, pat_sel}, 64'd1);
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("no_step_pat", {60'd0, pat_sel}, 64'd1);

    for (int c = 0; c < FRAME; c++)
      applyStimulus(1'b1, 1'b1, (c == FRAME - 1) ? 1'b1 : 1'b0);
    checkOutput("coinc_pat", {60'd0, pat_sel}, 64'd2);
    repeat (FRAME) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("coinc_no_extra", {60'd0, pat_sel}, 64'd2);

    repeat (5 * PERIOD + BLANK_TICKS + 2) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0, (c == 10) ? 1'b1 : 1'b0);
    checkOutput("en_hold_row", {60'd0, row_bin}, 64'd5);
    checkOutput("en_dark", {32'd0, row_out, col_out}, 64'd0);
    repeat (11 * PERIOD) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("en_step_pat", {60'd0, pat_sel}, 64'd0);

    for (int c = 0; c < FRAME; c++) applyStimulus(1'b1, 1'b0, (c == 3) ? 1'b1 : 1'b0);
    checkOutput("pre_rst_pat", {60'd0, pat_sel}, 64'd1);
    repeat (9 * PERIOD + BLANK_TICKS + 2) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_lit", {48'd0, row_out}, 64'h0200);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", {23'd0, row_bin, pat_sel, row_out, col_out, frame_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (2 * PERIOD) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_restart_row", {56'd0, row_bin, pat_sel}, 64'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Row-scan sequencer for the 16x16 LED dot-matrix display.
- Drives a 4-bit row index to the combinational pattern ROMs and drives a pattern-select code to the external ROM mux.
- Registers the returned 16-bit column word and drives one lit row at a time, with blanking between rows to suppress ghosting.
- Advances through the stored patterns (digits) automatically after a set number of frames, or on a manual step request, and only ever changes pattern on a frame boundary.

Parameters:
- ROW_TICKS, 2500: clock cycles each row is lit (SHOW phase).
- BLANK_TICKS, 8: clock cycles of dark time before each row fetch; must be >= 1.
- FRAMES_PER_PAT, 100: complete frames shown per pattern in auto mode; must be >= 1.
- NUM_PAT, 10: number of patterns; pat_sel wraps after NUM_PAT-1; range 1..16.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = scan runs; 0 = display dark, position held.
- auto_en  in  1  1 = advance pattern every FRAMES_PER_PAT frames.
- step  in  1  single-cycle pulse (already debounced); requests advance by one pattern.
- pat_col_in  in  16  column word returned by the selected ROM for row_bin.
- row_bin  out  4  current row index to the pattern ROMs.
- pat_sel  out  4  current pattern index to the ROM mux.
- row_out  out  16  one-hot row drive, active high; bit k lights row k.
- col_out  out  16  column drive, active high.
- frame_done  out  1  one-cycle pulse at the end of row 15 SHOW.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state BLANK, row index 0, phase counter 0, frame counter 0, step_pending 0.
  - row_bin=0, pat_sel=0, row_out=0, col_out=0, frame_done=0.
- FSM states are BLANK, FETCH and SHOW; all outputs are registered.
- BLANK:
  - row_out=0, col_out=0.
  - Stays BLANK_TICKS cycles, then goes to FETCH.
- FETCH:
  - Lasts exactly 1 cycle; row_out=0.
  - pat_col_in is sampled into the column register at the end of this cycle (row_bin has been stable since BLANK entry).
- SHOW:
  - row_out = 1<<row index, col_out = captured column word; held for ROW_TICKS cycles.
  - At the end of SHOW: row index increments mod 16, row_bin updates and the FSM goes to BLANK.
- Row period = BLANK_TICKS + 1 + ROW_TICKS cycles; frame = 16 row periods.
- Frame boundary is the final SHOW cycle of row 15. On the following edge:
  - frame_done=1 for exactly one cycle.
  - Row index wraps to 0.
  - Frame counter increments, or clears when it was FRAMES_PER_PAT-1.
- Pattern advance:
  - Evaluated only at the frame boundary.
  - Advance when (auto_en=1 and frame counter == FRAMES_PER_PAT-1) or step_pending=1.
  - Advance = pat_sel+1, wrapping NUM_PAT-1 -> 0. The update is on the same edge as the row wrap, so the next FETCH reads the new pattern.
  - Auto and step coinciding at one boundary: advance by exactly one; step_pending clears.
  - Auto advance does not clear the frame counter beyond its normal wrap. A step advance does not alter the frame counter.
- step handling:
  - A pulse sets step_pending at any time; it is cleared only at the boundary that consumes it.
  - Multiple pulses within one frame produce one advance.
  - A pulse arriving on the boundary edge itself is consumed at that boundary.
- en=0:
  - Next edge: state forced to BLANK, row_out=0, col_out=0, phase counter cleared.
  - Row index, row_bin, pat_sel, frame counter and step_pending are held; step pulses are still latched.
  - No frame_done while en=0.
  - When en returns to 1: full BLANK_TICKS then FETCH of the same row, so the interrupted row is re-shown in full.
- NUM_PAT=1: pat_sel stays 0; advances are consumed with no visible change.
- The row_out and col_out pair never shows a row with a stale column word: col_out changes only while row_out=0.

Test Plan (ROW_TICKS=4, BLANK_TICKS=2, FRAMES_PER_PAT=2, NUM_PAT=3; row period 7, frame 112 cycles):
- Reset then release, en=1, auto_en=0 -> all outputs 0. Cycles 1-2 dark; row 0 lit cycles 4-7 with col_out = pat_col_in sampled at cycle 3; row_bin=1 from cycle 8.
- Run a full frame, ROM model col=row_bin*0x1111 -> row_out walks 0x0001..0x8000 with col_out 0x0000..0xFFFF. frame_done is high for one cycle at cycle 112; no cycle has row_out!=0 with col_out from the previous row.
- auto_en=1 for 5 frames -> pat_sel 0,0,1,1,2 then wraps to 0 after frame 6. Every change coincides with row_bin 15->0.
- Three step pulses mid-frame plus auto_en=0 -> single advance 0->1 at the next boundary. A step on the boundary cycle when auto would also advance -> pat_sel +1 only.
- Drop en during row 5 SHOW for 20 cycles -> outputs 0 next edge, row_bin stays 5. Resume gives 2 dark cycles, FETCH, then row 5 shown 4 full cycles.
- Assert rst_n low mid-SHOW of row 9, asynchronously -> outputs clear immediately without a clock edge; after release the scan restarts at row 0, pat_sel 0.
